// File: rtl/int_responder_if.sv
// Bundle of the responder's peripheral, register-decode and sequencer signals.
// Purely structural; no latency of its own.
// No backpressure; the sequencer's INT_ACK level is the only handshake.
interface int_responder_if;
  logic [4:0] IRQ;
  logic       REG_SEL;
  logic       REG_WR;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       M1;
  logic       EI_REQ;
  logic       DI_REQ;
  logic       RETI_REQ;
  logic       INT_ACK;
  logic       INT_REQ;
  logic       WAKE;
  logic       VEC_VALID;
  logic [7:0] VECTOR;
  logic       IME;

  // Sequencer / decode / peripheral side
  modport master (
    output IRQ, REG_SEL, REG_WR, DIN, M1, EI_REQ, DI_REQ, RETI_REQ, INT_ACK,
    input  DOUT, INT_REQ, WAKE, VEC_VALID, VECTOR, IME
  );

  // Responder side
  modport slave (
    input  IRQ, REG_SEL, REG_WR, DIN, M1, EI_REQ, DI_REQ, RETI_REQ, INT_ACK,
    output DOUT, INT_REQ, WAKE, VEC_VALID, VECTOR, IME
  );
endinterface

// File: rtl/int_responder.sv
// Interrupt responder: IF/IE/IME registers, request edge detect, dispatch vector.
// Latency: IRQ edge -> IF next edge; INT_ACK edge -> VECTOR/VEC_VALID after that edge.
// No backpressure: VEC_VALID is held while the sequencer keeps INT_ACK high.
module int_responder (
  input logic            CLK,
  input logic            nRESET,
  int_responder_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state, state_next;
  logic [4:0] irq_q;
  logic [4:0] if_r;
  logic [7:0] ie_r;
  logic       ime_r;
  logic       ei_pend;
  logic [7:0] vector_r;
  logic       vec_valid_r;

  logic [4:0] set;
  logic       wr_if;
  logic       wr_ie;
  logic [7:0] ie_eff;
  logic [4:0] pend;
  logic       dispatch;
  logic       release_ack;
  logic       pend_any;
  logic [2:0] win;
  logic [4:0] clr;
  logic [4:0] if_next;

  assign set   = bus.IRQ & ~irq_q;
  assign wr_if = bus.REG_WR & ~bus.REG_SEL;
  assign wr_ie = bus.REG_WR & bus.REG_SEL;
  // A same-cycle IE write takes part in the dispatch decision.
  assign ie_eff = wr_ie ? bus.DIN : ie_r;
  assign pend   = if_r & ie_eff[4:0];

  // Dispatch FSM next state and the dispatch/release decisions
  always_comb begin
    state_next  = state;
    dispatch    = 1'b0;
    release_ack = 1'b0;
    case (state)
      IDLE: begin
        if (bus.INT_ACK) begin
          dispatch   = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!bus.INT_ACK) begin
          release_ack = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lowest pending request wins; clear only that bit, only on dispatch
  always_comb begin
    win      = 3'd0;
    pend_any = |pend;
    for (int i = 4; i >= 0; i--) begin
      if (pend[i]) win = 3'(i);
    end
    clr = (dispatch && pend_any) ? (5'b00001 << win) : 5'b00000;
  end

  // Edge set beats both the write and the dispatch clear
  assign if_next = ((wr_if ? bus.DIN[4:0] : if_r) & ~clr) | set;

  // FSM state register
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_next;
  end

  // IF, IE and the request edge detector
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      irq_q <= 5'h00;
      if_r  <= 5'h00;
      ie_r  <= 8'h00;
    end else begin
      irq_q <= bus.IRQ;
      if_r  <= if_next;
      if (wr_ie) ie_r <= bus.DIN;
    end
  end

  // Master enable; EI takes effect only at the following instruction boundary
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ime_r   <= 1'b0;
      ei_pend <= 1'b0;
    end else if (bus.DI_REQ || dispatch) begin
      ime_r   <= 1'b0;
      ei_pend <= 1'b0;
    end else if (bus.RETI_REQ) begin
      ime_r <= 1'b1;
    end else if (bus.EI_REQ) begin
      ei_pend <= 1'b1;
    end else if (bus.M1 && ei_pend) begin
      ime_r   <= 1'b1;
      ei_pend <= 1'b0;
    end
  end

  // Vector output; a cancelled dispatch returns vector 00
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      vector_r    <= 8'h00;
      vec_valid_r <= 1'b0;
    end else if (dispatch) begin
      vector_r    <= pend_any ? (8'h40 + {2'b00, win, 3'b000}) : 8'h00;
      vec_valid_r <= 1'b1;
    end else if (release_ack) begin
      vec_valid_r <= 1'b0;
    end
  end

  assign bus.DOUT      = bus.REG_SEL ? ie_r : {3'b111, if_r};
  assign bus.WAKE      = |(if_r & ie_r[4:0]);
  assign bus.INT_REQ   = bus.WAKE & ime_r;
  assign bus.VEC_VALID = vec_valid_r;
  assign bus.VECTOR    = vector_r;
  assign bus.IME       = ime_r;

endmodule
